// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding.
package serial_add_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic cout
);

  assign sum  = A ^ B ^ Cin;
  assign cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first addition through one full adder,
// one bit per RUN cycle, with registered result, carry, busy and done.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fa_sum;
  logic               fa_cout;

  full_adder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          sum_d   = res_d;
          cout_d  = fa_cout;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 addition; called at a negedge, returns at a negedge.
  // At RUN cycle act_n the operand inputs are overwritten and start optionally re-pulsed.
  task automatic do_add8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic [7:0] es, input logic ec,
                         input int act_n, input logic [7:0] a2, input logic [7:0] b2,
                         input logic c2, input logic act_start);
    logic [7:0] prev;
    int n;
    prev   = sum8;
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = ci;
    @(posedge clk); #1;
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    start8 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      start8 = 1'b0;
      if (n == 4) check({tag, "_hold"}, 32'(sum8), 32'(prev));
      if (done8) break;
      if (n == act_n) begin
        a8 = a2; b8 = b2; cin8 = c2; start8 = act_start;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'd9);
    check({tag, "_sum"}, 32'(sum8), 32'(es));
    check({tag, "_cout"}, 32'(cout8), 32'(ec));
    check({tag, "_idle"}, 32'(busy8), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done8), 32'd0);
    check({tag, "_norestart"}, 32'(busy8), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dcount;
    logic [4:0] exp5;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_sum4", 32'({cout4, sum4}), 32'd0);

    // First start presented together with reset release.
    @(negedge clk);
    rst = 1'b0;
    do_add8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_add8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_add8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_add8("restart_ign", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3, 8'hFF, 8'hFF, 1'b1, 1'b1);
    do_add8("late_ops", 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1, 8'hAA, 8'h77, 1'b0, 1'b0);

    // Reset during the 4th RUN cycle.
    start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sum", 32'(sum8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dcount++;
    end
    check("midrst_nodone", 32'(dcount), 32'd0);
    @(negedge clk);
    do_add8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0);

    // WIDTH=4 exhaustive with start held high.
    start4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      cin4 = v[8]; a4 = v[7:4]; b4 = v[3:0];
      exp5 = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
      n = 0;
      while (n < 20) begin
        @(posedge clk); #1;
        n++;
        if (done4) break;
      end
      check("w4_period", 32'(n), 32'd6);
      check("w4_result", 32'({cout4, sum4}), 32'(exp5));
      @(negedge clk);
    end
    start4 = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
